mining_lane_controller: RTL and testbench
=========================================

# mining_lane_controller

Parametrised nonce-dispatch and result-collection controller for a multi-lane SHA-256d mining array. It accepts a mining job (nonce range plus 256-bit target) through a valid/ready handshake. Each cycle it issues groups of LANES consecutive nonces to external double-SHA-256 hash lanes, tracks in-flight groups, and compares returned hashes against the target. It reports the lowest winning nonce, or exhaustion of the range. It replaces the single-nonce, free-running top level with a job-driven, range-bounded, multi-lane engine.

## Interface
- LANES, 4: hash lanes per group (power of two, 1..16)
- MAX_INFLIGHT, 256: maximum issued-but-unreturned groups; must be ≥ the lane pipeline depth for full throughput
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  controller can accept a job
- job_nonce_start  in  32  first nonce, inclusive
- job_nonce_end  in  32  last nonce, inclusive; must be ≥ start
- job_target  in  256  hash must be strictly less than this (unsigned)
- abort  in  1  stop the current job
- lane_issue  out  1  lane_nonce/lane_mask valid this cycle
- lane_nonce  out  32*LANES  lane i nonce at bits [32i+31:32i]
- lane_mask  out  LANES  lane i carries an in-range nonce
- lane_hash_valid  in  1  one returned group, in issue order
- lane_hash  in  256*LANES  lane i final hash at bits [256i+255:256i]
- busy  out  1  job in progress (RUN or DRAIN)
- done  out  1  job finished; held until next job accepted
- found  out  1  qualified by done; a hit occurred
- found_nonce  out  32  winning nonce; valid when found
- aborted  out  1  qualified by done; job ended by abort

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- job_ready = 1 in IDLE and DONE. A transfer occurs when job_valid && job_ready.
  - Latches start, end and target.
  - Sets base = start.
  - Clears found, found_nonce, done and aborted.
  - Next state is RUN.
- RUN issue rule: when outstanding < MAX_INFLIGHT, assert lane_issue with the following values, then set base += LANES and outstanding += 1.
  - lane_nonce[i] = base + i.
  - lane_mask[i] = (base + i ≤ end), computed in 33-bit arithmetic so nothing wraps.
- Last-group detection: the issue where base + LANES − 1 ≥ end, in 33-bit arithmetic. After that issue: RUN → DRAIN.
- end = 0xFFFFFFFF: the 33-bit base reaches 0x1_0000_0000, and no nonce wraps to 0.
- Return handling:
  - Each lane_hash_valid decrements outstanding.
  - Stage 1 registers lane_hash, the mask and the return nonce base. The return base starts at `start` and advances by LANES per return.
  - Stage 2 computes hit[i] = mask[i] && hash[i] < target. The lowest hit index wins.
  - The first hit of the job sets found and found_nonce. Later hits are ignored.
- lane_hash_valid while outstanding == 0 is ignored and does not underflow.
- abort in RUN, or on the job-accepting edge: no further issue, set aborted, go to DRAIN. abort in DRAIN has no further effect; in IDLE/DONE it is ignored.
- DRAIN → DONE when outstanding == 0 and both compare stages are empty. Results returned during DRAIN are still evaluated.
- Simultaneous issue and return in one cycle: outstanding is unchanged.

## Timing
- Job acceptance at edge T:
  - busy = 1 from T+1.
  - First lane_issue at T+1, then one group per cycle unless throttled by MAX_INFLIGHT.
- Hit latency: lane_hash_valid at edge R → found = 1 after edge R+2.
- done rises 1 cycle after the DRAIN exit condition is met. busy falls in the same cycle.
- Reset values:
  - job_ready = 1.
  - 0: busy, done, found, aborted, lane_issue, lane_mask.
  - 0: lane_nonce, found_nonce.
  - Counters 0.
- Reset asserted mid-job: returns to IDLE immediately. Results returning after reset are discarded by the outstanding == 0 rule.

## Configuration
- MINER_EARLY_EXIT_EN defined: the first hit in RUN immediately stops issue (RUN → DRAIN on the cycle found sets). Remaining in-flight results are drained and ignored.
- Undefined: the full range is always scanned. found_nonce is still the lowest hit because returns are in order. The interface is identical in both builds.

## Test plan
- LANES=4, start=0x10, end=0x1F, target=all-ones → 4 issues (bases 0x10, 0x14, 0x18, 0x1C), all masks 0xF; done with found=1, found_nonce=0x10.
- start=0x0, end=0x5, target=0 → 2 issues, second mask 0x3; done with found=0 after both returns.
- start=0xFFFFFFFC, end=0xFFFFFFFF, target=0 → exactly 1 issue, mask 0xF, no wrap; done, found=0.
- Lane 2 of group 3 and lane 0 of group 5 hit (start=0) → found_nonce=0xE.
  - EARLY_EXIT_EN: issue stops 2 cycles after group 3 returns.
  - Otherwise: all groups are issued.
- MAX_INFLIGHT=2 with returns withheld → exactly 2 issues, then lane_issue=0 until a return.
- abort 3 cycles after acceptance, results returned 10 cycles later → done, aborted=1, found=0; job_valid in the same cycle as done is accepted.

Source files
------------

// File: rtl/mining_lane_controller.sv
// Job-driven nonce dispatcher/result checker for LANES SHA-256d lanes; hit reported 2 cycles after return.
// Issue throttled by MAX_INFLIGHT outstanding groups; MINER_EARLY_EXIT_EN stops issue on the first hit.
module mining_lane_controller #(
  parameter int LANES        = 4,
  parameter int MAX_INFLIGHT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [31:0]           job_nonce_start,
  input  logic [31:0]           job_nonce_end,
  input  logic [255:0]          job_target,
  input  logic                  abort,
  output logic                  lane_issue,
  output logic [32*LANES-1:0]   lane_nonce,
  output logic [LANES-1:0]      lane_mask,
  input  logic                  lane_hash_valid,
  input  logic [256*LANES-1:0]  lane_hash,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [31:0]           found_nonce,
  output logic                  aborted
);

  localparam int OW = $clog2(MAX_INFLIGHT + 1);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [32:0]            r_base, r_ret_base;
  logic [31:0]            r_end;
  logic [255:0]           r_target;
  logic [OW-1:0]          r_outstanding;
  logic                   r_s1_vld;
  logic [256*LANES-1:0]   r_s1_hash;
  logic [LANES-1:0]       r_s1_mask;
  logic [31:0]            r_s1_base;
  logic                   r_s2_vld, r_s2_hit;
  logic [31:0]            r_s2_nonce;
  logic                   r_found, r_aborted;
  logic [31:0]            r_found_nonce;

  logic                   w_accept, w_ret, w_found_set, w_last, w_drained;
  logic [LANES-1:0]       w_hit;
  logic [IW-1:0]          w_idx;

  assign job_ready   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign found       = r_found;
  assign found_nonce = r_found_nonce;
  assign aborted     = r_aborted;

  assign w_accept    = job_valid && job_ready;
  // Returns with nothing outstanding are stale (e.g. from before a reset) and dropped.
  assign w_ret       = lane_hash_valid && (r_outstanding != '0);
  assign w_found_set = r_s2_vld && r_s2_hit && !r_found;
  assign w_last      = (r_base + 33'(LANES - 1)) >= {1'b0, r_end};
  assign w_drained   = (r_outstanding == '0) && !r_s1_vld && !r_s2_vld;

  always_comb begin
    lane_issue = (r_state == S_RUN) && !abort && (r_outstanding < OW'(MAX_INFLIGHT));
    lane_nonce = '0;
    lane_mask  = '0;
    if (lane_issue) begin
      for (int i = 0; i < LANES; i++) begin
        lane_nonce[32*i +: 32] = r_base[31:0] + 32'(i);
        lane_mask[i]           = (r_base + 33'(i)) <= {1'b0, r_end};
      end
    end
  end

  always_comb begin
    w_hit = '0;
    w_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      w_hit[i] = r_s1_mask[i] && (r_s1_hash[256*i +: 256] < r_target);
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_idx = IW'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = abort ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (abort) w_state_nxt = S_DRAIN;
`ifdef MINER_EARLY_EXIT_EN
        else if (w_found_set) w_state_nxt = S_DRAIN;
`endif
        else if (lane_issue && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drained) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base        <= '0;
      r_ret_base    <= '0;
      r_end         <= '0;
      r_target      <= '0;
      r_outstanding <= '0;
      r_s1_vld      <= 1'b0;
      r_s1_hash     <= '0;
      r_s1_mask     <= '0;
      r_s1_base     <= '0;
      r_s2_vld      <= 1'b0;
      r_s2_hit      <= 1'b0;
      r_s2_nonce    <= '0;
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_aborted     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_end         <= job_nonce_end;
        r_target      <= job_target;
        r_base        <= {1'b0, job_nonce_start};
        r_ret_base    <= {1'b0, job_nonce_start};
        r_found       <= 1'b0;
        r_found_nonce <= '0;
        r_aborted     <= abort;
      end else begin
        if (r_state == S_RUN && abort) r_aborted <= 1'b1;
        if (w_found_set) begin
          r_found       <= 1'b1;
          r_found_nonce <= r_s2_nonce;
        end
      end

      if (lane_issue) r_base <= r_base + 33'(LANES);

      if (lane_issue && !w_ret)      r_outstanding <= r_outstanding + OW'(1);
      else if (!lane_issue && w_ret) r_outstanding <= r_outstanding - OW'(1);

      // Returns arrive in issue order, so the mask is rebuilt from a parallel return base.
      r_s1_vld <= w_ret;
      if (w_ret) begin
        r_s1_hash  <= lane_hash;
        r_s1_base  <= r_ret_base[31:0];
        r_ret_base <= r_ret_base + 33'(LANES);
        for (int i = 0; i < LANES; i++) begin
          r_s1_mask[i] <= (r_ret_base + 33'(i)) <= {1'b0, r_end};
        end
      end

      r_s2_vld   <= r_s1_vld;
      r_s2_hit   <= r_s1_vld && (|w_hit);
      r_s2_nonce <= r_s1_base + 32'(w_idx);
    end
  end

endmodule

// File: tb/tb_mining_lane_controller.sv
module tb_mining_lane_controller;
  localparam int LANES = 4;
  localparam int MAXI  = 2;
`ifdef MINER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  job_valid, job_ready, abort;
  logic [31:0]           job_nonce_start, job_nonce_end;
  logic [255:0]          job_target;
  logic                  lane_issue;
  logic [32*LANES-1:0]   lane_nonce;
  logic [LANES-1:0]      lane_mask;
  logic                  lane_hash_valid;
  logic [256*LANES-1:0]  lane_hash;
  logic                  busy, done, found, aborted;
  logic [31:0]           found_nonce;

  always #5 clk = ~clk;

  mining_lane_controller #(.LANES(LANES), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end), .job_target(job_target),
    .abort(abort), .lane_issue(lane_issue), .lane_nonce(lane_nonce), .lane_mask(lane_mask),
    .lane_hash_valid(lane_hash_valid), .lane_hash(lane_hash), .busy(busy), .done(done),
    .found(found), .found_nonce(found_nonce), .aborted(aborted)
  );

  typedef struct {
    logic [31:0] base;
    int          t;
  } grp_t;

  typedef struct {
    logic [31:0]      s;
    logic [31:0]      e;
    logic [255:0]     tg;
    int               mode;
    int               exp_issues;
    logic [LANES-1:0] exp_last_mask;
    bit               exp_found;
    logic [31:0]      exp_nonce;
  } vec_t;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  grp_t             q[$];
  int               n_issue = 0;
  logic [LANES-1:0] last_mask;
  longint           cur_s = 0;
  longint           cur_e = 0;
  int               hmode = 0;
  logic [31:0]      salt = '0;
  bit               ret_en = 1'b1;
  int               ret_lat = 2;

  function automatic logic [255:0] hash_of(input logic [31:0] n);
    if (hmode == 1) return (n == 32'hE || n == 32'h14) ? 256'h0 : {256{1'b1}};
    return {(n * 32'h9E3779B1) ^ salt, 224'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every issued group is compared against the nonce range arithmetic.
  always @(posedge clk) begin
    cyc++;
    if (lane_issue) begin
      longint           eb;
      logic [32*LANES-1:0] en;
      logic [LANES-1:0] em;
      eb = cur_s + longint'(LANES) * longint'(n_issue);
      en = '0;
      em = '0;
      for (int i = 0; i < LANES; i++) begin
        en[32*i +: 32] = 32'(eb + i);
        em[i]          = (eb + i) <= cur_e;
      end
      checks++;
      if (lane_nonce !== en || lane_mask !== em) begin
        errors++;
        $display("FAIL issue_group %0d: got nonce0 %0h mask %0h expected nonce0 %0h mask %0h",
                 n_issue, lane_nonce[31:0], lane_mask, en[31:0], em);
      end
      q.push_back('{base: lane_nonce[31:0], t: cyc});
      n_issue++;
      last_mask = lane_mask;
    end
  end

  initial begin
    grp_t g;
    lane_hash_valid = 1'b0;
    lane_hash       = '0;
    forever begin
      @(negedge clk);
      lane_hash_valid = 1'b0;
      if (ret_en && q.size() > 0 && cyc >= q[0].t + ret_lat && $urandom_range(0, 3) != 0) begin
        g = q.pop_front();
        for (int i = 0; i < LANES; i++) lane_hash[256*i +: 256] = hash_of(g.base + 32'(i));
        lane_hash_valid = 1'b1;
      end
    end
  end

  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tg, input int ab_at);
    chk("job_ready_before", {63'd0, job_ready}, 64'd1);
    cur_s = longint'(s);
    cur_e = longint'(e);
    n_issue = 0;
    last_mask = '0;
    job_nonce_start = s;
    job_nonce_end   = e;
    job_target      = tg;
    job_valid       = 1'b1;
    abort           = (ab_at == 0);
    @(negedge clk);
    job_valid = 1'b0;
    abort     = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("done_cleared", {63'd0, done}, 64'd0);
    if (ab_at != 0) chk("first_issue_t1", {63'd0, lane_issue}, 64'd1);
    if (ab_at > 0) begin
      repeat (ab_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", {63'd0, done}, 64'd1);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{32'h10, 32'h1F, {256{1'b1}}, 0, 4, 4'hF, 1'b1, 32'h10};
    tbl[1] = '{32'h0, 32'h5, 256'h0, 0, 2, 4'h3, 1'b0, 32'h0};
    tbl[2] = '{32'hFFFFFFFC, 32'hFFFFFFFF, 256'h0, 0, 1, 4'hF, 1'b0, 32'h0};
    tbl[3] = '{32'h0, 32'h3F, 256'h1, 1, 16, 4'hF, 1'b1, 32'hE};

    reset = 1'b0; job_valid = 1'b0; abort = 1'b0;
    job_nonce_start = '0; job_nonce_end = '0; job_target = '0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", {63'd0, job_ready}, 64'd1);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_found_abort", {62'd0, found, aborted}, 64'd0);
    chk("rst_issue_mask", {59'd0, lane_issue, lane_mask}, 64'd0);
    chk("rst_nonces", {lane_nonce[63:32] | lane_nonce[127:96], lane_nonce[31:0] | lane_nonce[95:64]}, 64'd0);
    chk("rst_found_nonce", {32'd0, found_nonce}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      hmode = tbl[k].mode;
      run_job(tbl[k].s, tbl[k].e, tbl[k].tg, -1);
      wait_done();
      chk("tbl_found", {63'd0, found}, {63'd0, tbl[k].exp_found});
      if (tbl[k].exp_found) chk("tbl_found_nonce", {32'd0, found_nonce}, {32'd0, tbl[k].exp_nonce});
      chk("tbl_aborted", {63'd0, aborted}, 64'd0);
      if (EE && tbl[k].exp_found) begin
        chk("tbl_issues_ee", {63'd0, n_issue <= tbl[k].exp_issues}, 64'd1);
      end else begin
        chk("tbl_issues", 64'(n_issue), 64'(tbl[k].exp_issues));
        chk("tbl_last_mask", {60'd0, last_mask}, {60'd0, tbl[k].exp_last_mask});
      end
    end
    hmode = 0;

    // Stray return while idle must not underflow the in-flight count.
    q.push_back('{base: 32'h0, t: 0});
    repeat (20) @(negedge clk);
    chk("stray_consumed", 64'(q.size()), 64'd0);
    chk("stray_idle", {62'd0, busy, done}, 64'd1);
    ret_en = 1'b0;
    run_job(32'h0, 32'hFF, 256'h0, -1);
    repeat (10) @(negedge clk);
    chk("throttle_issues", 64'(n_issue), 64'd2);
    chk("throttle_no_issue", {63'd0, lane_issue}, 64'd0);
    ret_en = 1'b1;
    wait_done();
    chk("throttle_total", 64'(n_issue), 64'd64);
    chk("throttle_found", {63'd0, found}, 64'd0);

    // Abort 3 cycles in, results held back, then released.
    ret_en = 1'b0;
    run_job(32'h0, 32'hFF, 256'h0, 3);
    repeat (10) @(negedge clk);
    chk("abort_drain_wait", {62'd0, busy, done}, 64'd2);
    ret_en = 1'b1;
    wait_done();
    chk("abort_flag", {63'd0, aborted}, 64'd1);
    chk("abort_found", {63'd0, found}, 64'd0);
    chk("abort_issues", 64'(n_issue), 64'd2);
    run_job(32'h100, 32'h107, {256{1'b1}}, -1);
    wait_done();
    chk("after_abort_cleared", {63'd0, aborted}, 64'd0);
    chk("after_abort_found", {32'd0, found_nonce}, 64'h100);

    run_job(32'h40, 32'h7F, {256{1'b1}}, 0);
    wait_done();
    chk("abort_at_accept", {63'd0, aborted}, 64'd1);
    chk("abort_at_accept_issues", 64'(n_issue), 64'd0);

    // Reset mid-job; late returns afterwards must be ignored.
    ret_en = 1'b0;
    run_job(32'h0, 32'hFF, {256{1'b1}}, -1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_idle", {61'd0, busy, job_ready, lane_issue}, 64'd2);
    @(negedge clk);
    reset = 1'b1;
    ret_en = 1'b1;
    for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("midrst_ignored", {61'd0, busy, done, found}, 64'd0);

    for (int r = 0; r < 20; r++) begin
      logic [31:0]  s;
      longint       el;
      logic [255:0] tg;
      bit           fm;
      logic [31:0]  nm;
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
      el = longint'(s) + longint'($urandom_range(0, 40));
      if (el > 64'hFFFFFFFF) el = 64'hFFFFFFFF;
      salt = $urandom;
      tg = {32'($urandom_range(0, 32'h20000000)), 224'h0};
      fm = 1'b0;
      nm = '0;
      for (longint n = longint'(s); n <= el; n++) begin
        if (hash_of(n[31:0]) < tg) begin
          fm = 1'b1;
          nm = n[31:0];
          break;
        end
      end
      run_job(s, el[31:0], tg, -1);
      wait_done();
      chk("rnd_found", {63'd0, found}, {63'd0, fm});
      if (fm) chk("rnd_found_nonce", {32'd0, found_nonce}, {32'd0, nm});
      if (!(EE && fm)) chk("rnd_issues", 64'(n_issue), 64'((el - longint'(s) + LANES) / LANES));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
